// File: rtl/mac_tile_dual.sv
// Dual-dataflow systolic PE: weight-stationary or output-stationary, chosen while idle.
// Optional macro MAC_TILE_SAT_EN: saturating arithmetic and the sticky sat_flag output.
module mac_tile_dual #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [1:0]         inst_w,
    output logic [1:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s,
    output logic               out_s_valid
`ifdef MAC_TILE_SAT_EN
    ,
    output logic               sat_flag
`endif
);

    typedef enum logic [1:0] {EMPTY, LOADED, DRAIN} state_t;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_LOAD  = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;
    localparam logic [1:0] INST_FLUSH = 2'b11;

    state_t                     state_q;
    logic                       mode_q;
    logic [1:0]                 inst_q;
    logic [bw-1:0]              a_q, b_q;
    logic signed [psum_bw-1:0]  c_q, acc_q, os_out_q;
    logic                       valid_q;

    logic signed [psum_bw-1:0]  ws_prod, os_prod, ws_sum, acc_d;

    // Unsigned activation times signed weight, sign-extended to the psum width.
    function automatic logic signed [psum_bw-1:0] mul(input logic [bw-1:0] a,
                                                      input logic [bw-1:0] b);
        logic signed [2*bw:0] p;
        p = $signed({{bw{1'b0}}, a}) * $signed({{(bw+1){b[bw-1]}}, b});
        return psum_bw'(p);
    endfunction

    assign ws_prod = mul(a_q, b_q);
    assign os_prod = mul(in_w, in_n[bw-1:0]);

`ifdef MAC_TILE_SAT_EN
    logic ws_clip, acc_clip, sat_q;

    // Returns {clipped, value}; one guard bit exposes the signed overflow.
    function automatic logic [psum_bw:0] sat_add(input logic signed [psum_bw-1:0] x,
                                                 input logic signed [psum_bw-1:0] y);
        logic [psum_bw:0] s;
        s = {x[psum_bw-1], x} + {y[psum_bw-1], y};
        if (s[psum_bw] != s[psum_bw-1])
            return {1'b1, s[psum_bw], {(psum_bw-1){~s[psum_bw]}}};
        return {1'b0, s[psum_bw-1:0]};
    endfunction

    assign {ws_clip, ws_sum} = sat_add(ws_prod, c_q);
    assign {acc_clip, acc_d} = sat_add(acc_q, os_prod);

    always_ff @(posedge clk) begin
        if (!reset)
            sat_q <= 1'b0;
        else if (mode_q && inst_w == INST_FLUSH && state_q != DRAIN)
            sat_q <= 1'b0;
        else if (mode_q ? (inst_w == INST_EXEC && acc_clip) : ws_clip)
            sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`else
    assign ws_sum = ws_prod + c_q;
    assign acc_d  = acc_q + os_prod;
`endif

    // NOTE: every register in the tile is reset, so a reset mid-operation drops the weight and the accumulator.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= EMPTY;
            mode_q   <= 1'b0;
            inst_q   <= INST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            os_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            inst_q <= inst_w;
            if (inst_w != INST_IDLE)
                a_q <= in_w;
            if (state_q == EMPTY && inst_w == INST_IDLE)
                mode_q <= mode;

            if (!mode_q) begin
                // A later load in LOADED just shifts the word east through a_q.
                if (inst_w == INST_LOAD && state_q == EMPTY) begin
                    b_q     <= in_w;
                    state_q <= LOADED;
                end
                if (inst_w[1])
                    c_q <= in_n;
            end else if (inst_w == INST_FLUSH) begin
                valid_q <= 1'b1;
                if (state_q != DRAIN) begin
                    os_out_q <= acc_q;
                    acc_q    <= '0;
                    state_q  <= DRAIN;
                end else begin
                    os_out_q <= in_n;
                end
            end else begin
                valid_q <= 1'b0;
                if (state_q == DRAIN)
                    state_q <= EMPTY;
                if (inst_w == INST_EXEC) begin
                    acc_q    <= acc_d;
                    os_out_q <= psum_bw'(in_n[bw-1:0]);
                end
            end
        end
    end

    assign out_e       = a_q;
    assign inst_e      = inst_q;
    assign out_s       = mode_q ? os_out_q : ws_sum;
    assign out_s_valid = valid_q;

endmodule
